// File: rtl/alu_pkg.sv
// Shared types for the ALU operation responder: opcode encoding, default
// widths and the response record carried from the compute stage to the initiator.
package alu_pkg;

   localparam int DEF_WIDTH = 6;
   localparam int DEF_TAG_W = 2;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_AND = 2'b10,
      OP_OR  = 2'b11
   } op_t;

   typedef struct packed {
      logic [DEF_WIDTH-1:0] result;
      logic                 gt_zero;
      logic                 sf;
      logic                 cf;
      logic                 zf;
      logic [DEF_TAG_W-1:0] tag;
   } rsp_t;

endpackage

// File: rtl/resp_fifo.sv
// In-order synchronous FIFO for response records; exposes its occupancy so the
// owner can reserve space before committing a request.
module resp_fifo
   import alu_pkg::*;
#(
   parameter type T     = rsp_t,
   parameter int  DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_i,
   input  T                         wdata_i,
   input  logic                     pop_i,
   output T                         rdata_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   T                 mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] cnt_q;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
         cnt_q <= cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = cnt_q;

endmodule

// File: rtl/alu_op_responder.sv
// Responder end of the ALU operation channel: one registered compute stage
// feeding an in-order response FIFO, with space reserved at request accept time.
module alu_op_responder
   import alu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = 2,
   parameter int TAG_W = DEF_TAG_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic [1:0]       req_op,
   input  logic [TAG_W-1:0] req_tag,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_gt_zero,
   output logic             rsp_sf,
   output logic             rsp_cf,
   output logic             rsp_zf,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             busy,
   output logic [15:0]      op_count
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [WIDTH-1:0] result;
      logic             gt_zero;
      logic             sf;
      logic             cf;
      logic             zf;
      logic [TAG_W-1:0] tag;
   } rsp_w_t;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COMPUTE = 2'd1,
      S_HOLD    = 2'd2
   } state_t;

   // Bit WIDTH of the extended sum is the carry for ADD and the borrow for SUB.
   function automatic rsp_w_t alu_eval(input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b,
                                       input op_t              op,
                                       input logic [TAG_W-1:0] tag);
      logic [WIDTH:0] sum;
      rsp_w_t         r;
      sum = '0;
      unique case (op)
         OP_ADD: sum = {1'b0, a} + {1'b0, b};
         OP_SUB: sum = {1'b0, a} - {1'b0, b};
         OP_AND: sum = {1'b0, a & b};
         OP_OR:  sum = {1'b0, a | b};
      endcase
      r.result  = sum[WIDTH-1:0];
      r.cf      = sum[WIDTH];
      r.sf      = sum[WIDTH-1];
      r.zf      = (sum[WIDTH-1:0] == '0);
      r.gt_zero = !r.sf && !r.zf;
      r.tag     = tag;
      return r;
   endfunction

   state_t           state_q;
   logic             rdy_en_q;
   logic [15:0]      op_count_q;
   rsp_w_t           stage_p1_q;
   logic             vld_p1;
   rsp_w_t           head;
   rsp_w_t           rsp_out;
   logic [CNT_W-1:0] fifo_cnt;
   logic [CNT_W-1:0] outstanding;
   logic [CNT_W-1:0] cnt_nxt;
   logic             fifo_vld;
   logic             fire_req;
   logic             fire_rsp;

   assign vld_p1      = (state_q == S_COMPUTE);
   assign fifo_vld    = (fifo_cnt != '0);
   assign outstanding = fifo_cnt + CNT_W'(vld_p1);
   assign req_ready   = rdy_en_q && (outstanding < CNT_W'(DEPTH));
   assign fire_req    = req_valid && req_ready;
   assign fire_rsp    = fifo_vld && rsp_ready;
   assign cnt_nxt     = fifo_cnt + CNT_W'(vld_p1) - CNT_W'(fire_rsp);

   // Controller: COMPUTE exactly while the stage register holds a result.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         rdy_en_q   <= 1'b0;
         op_count_q <= '0;
      end else begin
         rdy_en_q <= 1'b1;
         if (fire_rsp) op_count_q <= op_count_q + 16'd1;
         unique case (state_q)
            S_IDLE, S_COMPUTE, S_HOLD: begin
               if (fire_req)                    state_q <= S_COMPUTE;
               else if (cnt_nxt == CNT_W'(DEPTH)) state_q <= S_HOLD;
               else                             state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Stage p1: compute on accept.
   always_ff @(posedge clk) begin
      if (fire_req) stage_p1_q <= alu_eval(req_a, req_b, op_t'(req_op), req_tag);
   end

   // Stage p2: stage result enters the FIFO; space was reserved at accept.
   resp_fifo #(
      .T     (rsp_w_t),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (vld_p1),
      .wdata_i (stage_p1_q),
      .pop_i   (fire_rsp),
      .rdata_o (head),
      .count_o (fifo_cnt)
   );

   assign rsp_out     = fifo_vld ? head : '0;
   assign rsp_valid   = fifo_vld;
   assign rsp_result  = rsp_out.result;
   assign rsp_gt_zero = rsp_out.gt_zero;
   assign rsp_sf      = rsp_out.sf;
   assign rsp_cf      = rsp_out.cf;
   assign rsp_zf      = rsp_out.zf;
   assign rsp_tag     = rsp_out.tag;
   assign busy        = vld_p1 || fifo_vld;
   assign op_count    = op_count_q;

endmodule

// File: tb/tb_alu_op_responder.sv
// Bench for alu_op_responder: a transaction-level model checked every cycle,
// plus directed operations with hand-computed results.
module tb_alu_op_responder;

   localparam int WIDTH = 6;
   localparam int DEPTH = 2;
   localparam int TAG_W = 2;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [WIDTH-1:0] req_a = '0;
   logic [WIDTH-1:0] req_b = '0;
   logic [1:0]       req_op = '0;
   logic [TAG_W-1:0] req_tag = '0;
   logic             rsp_valid;
   logic             rsp_ready = 1'b1;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_gt_zero;
   logic             rsp_sf;
   logic             rsp_cf;
   logic             rsp_zf;
   logic [TAG_W-1:0] rsp_tag;
   logic             busy;
   logic [15:0]      op_count;

   always #5 clk = ~clk;

   alu_op_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_op      (req_op),
      .req_tag     (req_tag),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_result  (rsp_result),
      .rsp_gt_zero (rsp_gt_zero),
      .rsp_sf      (rsp_sf),
      .rsp_cf      (rsp_cf),
      .rsp_zf      (rsp_zf),
      .rsp_tag     (rsp_tag),
      .busy        (busy),
      .op_count    (op_count)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: each accepted request yields one response, visible two cycles
   // after acceptance at the earliest and delivered in acceptance order.
   typedef struct {
      int res;
      int gz;
      int sf;
      int cf;
      int zf;
      int tag;
      int avail;
   } exp_t;

   exp_t q[$];
   int   accepted = 0;
   int   popped   = 0;
   int   rdy_en   = 0;
   int   cyc      = 0;

   function automatic exp_t model(input int a, input int b, input int op, input int tag);
      exp_t e;
      int   raw;
      raw = 0;
      e.cf = 0;
      case (op)
         0: begin raw = a + b; e.cf = (raw > 63) ? 1 : 0; end
         1: begin raw = a - b + 64; e.cf = (a < b) ? 1 : 0; end
         2: raw = a & b;
         default: raw = a | b;
      endcase
      e.res   = raw % 64;
      e.sf    = (e.res >= 32) ? 1 : 0;
      e.zf    = (e.res == 0) ? 1 : 0;
      e.gz    = (e.res > 0 && e.res < 32) ? 1 : 0;
      e.tag   = tag;
      e.avail = 0;
      return e;
   endfunction

   always @(negedge clk) begin
      int   outst;
      int   mv;
      exp_t e;
      outst = accepted - popped;
      mv    = (q.size() > 0 && q[0].avail <= cyc) ? 1 : 0;
      chk("req_ready", int'(req_ready), (rdy_en != 0 && outst < DEPTH) ? 1 : 0);
      chk("rsp_valid", int'(rsp_valid), mv);
      chk("busy", int'(busy), (outst != 0) ? 1 : 0);
      chk("op_count", int'(op_count), popped % 65536);
      if (mv != 0) begin
         chk("rsp_result", int'(rsp_result), q[0].res);
         chk("rsp_gt_zero", int'(rsp_gt_zero), q[0].gz);
         chk("rsp_sf", int'(rsp_sf), q[0].sf);
         chk("rsp_cf", int'(rsp_cf), q[0].cf);
         chk("rsp_zf", int'(rsp_zf), q[0].zf);
         chk("rsp_tag", int'(rsp_tag), q[0].tag);
      end
      if (reset) begin
         q.delete();
         accepted = 0;
         popped   = 0;
         rdy_en   = 0;
      end else begin
         if (mv != 0 && rsp_ready) begin
            void'(q.pop_front());
            popped++;
         end
         if (req_valid && rdy_en != 0 && outst < DEPTH) begin
            e = model(int'(req_a), int'(req_b), int'(req_op), int'(req_tag));
            e.avail = cyc + 2;
            q.push_back(e);
            accepted++;
         end
         rdy_en = 1;
      end
      cyc++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int a, input int b, input int op, input int tag);
      logic hs;
      logic done;
      req_a     = WIDTH'(a);
      req_b     = WIDTH'(b);
      req_op    = 2'(op);
      req_tag   = TAG_W'(tag);
      req_valid = 1'b1;
      done      = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         hs = req_ready;
         step();
         if (hs) done = 1'b1;
      end
      req_valid = 1'b0;
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_accept: request tag %0d not accepted within 40 cycles", tag);
      end
   endtask

   task automatic expect_rsp(input string name, input int res, input int gz, input int sf,
                             input int cf, input int zf, input int tag);
      int lat;
      logic found;
      lat   = 0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         lat++;
         if (rsp_valid) found = 1'b1;
      end
      chk({name, "_latency"}, lat, 2);
      chk({name, "_result"}, int'(rsp_result), res);
      chk({name, "_gt_zero"}, int'(rsp_gt_zero), gz);
      chk({name, "_sf"}, int'(rsp_sf), sf);
      chk({name, "_cf"}, int'(rsp_cf), cf);
      chk({name, "_zf"}, int'(rsp_zf), zf);
      chk({name, "_tag"}, int'(rsp_tag), tag);
      step();
   endtask

   task automatic wait_idle();
      logic idle;
      idle = 1'b0;
      for (int i = 0; i < 60 && !idle; i++) begin
         @(negedge clk);
         if (!busy) idle = 1'b1;
      end
      chk("drain_idle", int'(idle), 1);
      step();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset_rsp_valid", int'(rsp_valid), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_op_count", int'(op_count), 0);
      chk("ready_first_cycle", int'(req_ready), 0);
      step();
      @(negedge clk);
      chk("ready_after_reset", int'(req_ready), 1);
      step();

      // Directed arithmetic with hand-computed results.
      send(20, 15, 0, 1);
      expect_rsp("add_20_15", 35, 0, 1, 0, 0, 1);
      send(63, 1, 0, 2);
      expect_rsp("add_63_1", 0, 0, 0, 1, 1, 2);
      send(5, 9, 1, 3);
      expect_rsp("sub_5_9", 60, 0, 1, 1, 0, 3);
      send(9, 5, 1, 0);
      expect_rsp("sub_9_5", 4, 1, 0, 0, 0, 0);
      send(42, 30, 2, 1);
      expect_rsp("and", 10, 1, 0, 0, 0, 1);
      send(0, 0, 3, 2);
      expect_rsp("or_zero", 0, 0, 0, 0, 1, 2);

      // Backpressure: only DEPTH requests accepted while responses stall.
      rsp_ready = 1'b0;
      send(1, 1, 0, 0);
      send(2, 2, 0, 1);
      req_a = 6'd3; req_b = 6'd3; req_op = 2'd0; req_tag = 2'd2; req_valid = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("bp_req_ready", int'(req_ready), 0);
         chk("bp_rsp_valid", int'(rsp_valid), 1);
         chk("bp_head_tag", int'(rsp_tag), 0);
         chk("bp_head_result", int'(rsp_result), 2);
         step();
      end
      rsp_ready = 1'b1;
      send(3, 3, 0, 2);
      send(4, 4, 0, 3);
      wait_idle();
      chk("op_count_after_bp", int'(op_count), 10);

      // Back-to-back stream from a clean count.
      do_reset();
      for (int i = 0; i < 10; i++) send(i * 5, i + 1, i % 4, i % 4);
      wait_idle();
      chk("stream_op_count", int'(op_count), 10);
      chk("stream_busy", int'(busy), 0);

      // Reset with two responses buffered discards them.
      rsp_ready = 1'b0;
      send(7, 7, 0, 0);
      send(8, 8, 0, 1);
      repeat (3) step();
      @(negedge clk);
      chk("buffered_count", int'(rsp_valid), 1);
      step();
      reset = 1'b1;
      step();
      @(negedge clk);
      chk("midreset_rsp_valid", int'(rsp_valid), 0);
      chk("midreset_busy", int'(busy), 0);
      chk("midreset_op_count", int'(op_count), 0);
      step();
      reset = 1'b0;
      rsp_ready = 1'b1;
      send(9, 5, 1, 2);
      expect_rsp("post_reset_sub", 4, 1, 0, 0, 0, 2);
      repeat (3) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
